// File: rtl/rr_mux_arb_pkg.sv
// Shared types and sizes for the round-robin 4:1 mux arbiter.
package rr_mux_arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/mux_4_1.sv
// Generic 4:1 data mux selected by a 2-bit index.
module mux_4_1 #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [1:0]   sel,
    output logic [W-1:0] y
);

    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Rotating first-valid search over four requesters, starting at ptr.
module rr_pick4
    import rr_mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  sel_t             ptr,
    output sel_t             gnt_idx,
    output logic             any
);

    sel_t idx;

    // Walk the ring backwards so the entry closest to ptr is written last.
    always_comb begin
        idx     = '0;
        gnt_idx = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = sel_t'(ptr + sel_t'(k));
            if (req[idx]) begin
                gnt_idx = idx;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/rr_mux_arb.sv
// Round-robin arbiter sharing one 4:1 mux into a single output register.
// Optional per-requester grant counters when RR_MUX_ARB_STATS_EN is defined.
module rr_mux_arb
    import rr_mux_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output sel_t                    out_sel,
`ifdef RR_MUX_ARB_STATS_EN
    output logic [N_REQ*CNT_W-1:0]  grant_cnt,
`endif
    input  logic                    out_ready
);

    state_t            state_q, state_d;
    sel_t              ptr_q, ptr_d;
    sel_t              sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;

    sel_t              gnt_idx;
    logic              any_valid;
    logic [DATA_W-1:0] mux_y;
    logic              accept_en_c;
    logic              accept_c;

    rr_pick4 u_pick (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .any     (any_valid)
    );

    mux_4_1 #(.W(DATA_W)) u_mux (
        .d0  (req_data[0*DATA_W +: DATA_W]),
        .d1  (req_data[1*DATA_W +: DATA_W]),
        .d2  (req_data[2*DATA_W +: DATA_W]),
        .d3  (req_data[3*DATA_W +: DATA_W]),
        .sel (gnt_idx),
        .y   (mux_y)
    );

    // rst_n gates accept so no strobe escapes while reset is asserted.
    assign accept_en_c = (state_q == EMPTY) | out_ready;
    assign accept_c    = accept_en_c & any_valid & rst_n;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        data_d    = data_q;
        req_ready = '0;
        case (state_q)
            EMPTY: if (accept_c) state_d = FULL;
            FULL:  if (out_ready) state_d = accept_c ? FULL : EMPTY;
            default: state_d = EMPTY;
        endcase
        if (accept_c) begin
            req_ready[gnt_idx] = 1'b1;
            ptr_d              = sel_t'(gnt_idx + sel_t'(1));
            sel_d              = gnt_idx;
            data_d             = mux_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

`ifdef RR_MUX_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [N_REQ];

    // Saturating accept counters, one per requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_REQ); i++) cnt_q[i] <= '0;
        end else if (accept_c && (cnt_q[gnt_idx] != '1)) begin
            cnt_q[gnt_idx] <= cnt_q[gnt_idx] + CNT_W'(1);
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed self-checking bench for rr_mux_arb (stats checked when RR_MUX_ARB_STATS_EN is set).
module tb_rr_mux_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;
`ifdef RR_MUX_ARB_STATS_EN
    logic [31:0] grant_cnt;
`endif

    int vectors;
    int miscompares;

    rr_mux_arb #(.DATA_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
`ifdef RR_MUX_ARB_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] d, input logic [1:0] s);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".data"},  32'(out_data),  32'(d));
        chk({tag, ".sel"},   32'(out_sel),   32'(s));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req_valid   = 4'b1111;
        req_data    = 16'h4321;
        out_ready   = 1'b1;

        // Reset state, with all requesters valid.
        #12;
        chk_out("rst", 1'b0, 4'h0, 2'd0);
        chk("rst.ptr", 32'(dut.ptr_q), 32'd0);
        chk("rst.ready", 32'(req_ready), 32'd0);

        // Full round-robin with all four valid.
        rst_n = 1'b1;
        #1;
        chk("rr.ready0", 32'(req_ready), 32'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("rr%0d", i), 1'b1, 4'((i % 4) + 1), 2'(i % 4));
            chk($sformatf("rr%0d.ready", i), 32'(req_ready), 32'(1 << ((i + 1) % 4)));
        end
        chk("rr.ptr", 32'(dut.ptr_q), 32'd1);

        // Drain: no requesters, downstream ready.
        req_valid = 4'b0000;
        #1;
        chk("drain.ready", 32'(req_ready), 32'd0);
        tick();
        chk_out("drain1", 1'b0, 4'h1, 2'd0);
        chk("drain1.ptr", 32'(dut.ptr_q), 32'd1);
        tick();
        chk_out("drain2", 1'b0, 4'h1, 2'd0);
        chk("drain2.ptr", 32'(dut.ptr_q), 32'd1);

        // Stall: requester 2 only, downstream not ready.
        req_valid = 4'b0100;
        req_data  = 16'h0A00;
        out_ready = 1'b0;
        #1;
        chk("stall.ready_empty", 32'(req_ready), 32'b0100);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk_out($sformatf("stall%0d", i), 1'b1, 4'hA, 2'd2);
            chk($sformatf("stall%0d.ready", i), 32'(req_ready), 32'd0);
            chk($sformatf("stall%0d.ptr", i), 32'(dut.ptr_q), 32'd3);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("stall.release_ready", 32'(req_ready), 32'b0100);
        tick();
        chk_out("stall.reload", 1'b1, 4'hA, 2'd2);
        chk("stall.ptr", 32'(dut.ptr_q), 32'd3);

        // Wrap-around from ptr=3 with requesters 0 and 3.
        req_valid = 4'b1001;
        req_data  = 16'h7006;
        #1;
        chk("wrap.ready3", 32'(req_ready), 32'b1000);
        tick();
        chk_out("wrap3", 1'b1, 4'h7, 2'd3);
        chk("wrap3.ptr", 32'(dut.ptr_q), 32'd0);
        chk("wrap.ready0", 32'(req_ready), 32'b0001);
        tick();
        chk_out("wrap0", 1'b1, 4'h6, 2'd0);
        chk("wrap0.ptr", 32'(dut.ptr_q), 32'd1);

        // Reset mid-operation while holding word 5.
        req_valid = 4'b0010;
        req_data  = 16'h0050;
        tick();
        out_ready = 1'b0;
        chk_out("pre_rst", 1'b1, 4'h5, 2'd1);
        chk("pre_rst.ptr", 32'(dut.ptr_q), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 1'b0, 4'h0, 2'd0);
        chk("mid_rst.ptr", 32'(dut.ptr_q), 32'd0);
        chk("mid_rst.ready", 32'(req_ready), 32'd0);
        req_valid = 4'b1110;
        req_data  = 16'h4321;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst.ready", 32'(req_ready), 32'b0010);
        tick();
        chk_out("post_rst", 1'b1, 4'h2, 2'd1);
        chk("post_rst.ptr", 32'(dut.ptr_q), 32'd2);

`ifdef RR_MUX_ARB_STATS_EN
        // Requester 1 already has one accept since reset.
        req_valid = 4'b0010;
        repeat (199) tick();
        chk("stats.200", grant_cnt, 32'h0000_C800);
        repeat (101) tick();
        chk("stats.sat", grant_cnt, 32'h0000_FF00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
